vga_sync_generator: RTL and testbench



---
 rtl/vga_sync_generator_if.sv | 28 ++
 rtl/vga_sync_generator.sv | 133 +++++++++++++
 tb/tb_vga_sync_generator.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vga_sync_generator_if.sv
// Raster timing bundle carried from the sync generator to the colour driver.
// The generator drives every signal (master); the driver consumes them (slave).
interface vga_sync_generator_if;
    logic [9:0] current_row;
    logic [9:0] current_line;
    logic       enable;
    logic       hsync_out;
    logic       vsync_out;
    logic       frame_start;

    modport master (
        output current_row,
        output current_line,
        output enable,
        output hsync_out,
        output vsync_out,
        output frame_start
    );

    modport slave (
        input current_row,
        input current_line,
        input enable,
        input hsync_out,
        input vsync_out,
        input frame_start
    );
endinterface

// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: pixel-clock divider, horizontal/vertical
// counters, registered coordinates/enable, and hsync/vsync delayed to line
// up with the downstream registered colour output.
module vga_sync_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int SYNC_DELAY = 1
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    vga_sync_generator_if.master  vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Divider needs at least one bit even when CLK_DIV is 1.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;

    logic             w_pix_tick;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_active;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_frame_wrap;

    logic [9:0]       r_row;
    logic [9:0]       r_line;
    logic             r_enable;
    logic             r_hs;
    logic             r_vs;
    logic             r_frame_start;

    // Decode tick, wrap points and raw sync/active levels from the counters.
    always_comb begin
        w_pix_tick   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
        w_h_last     = (r_h_cnt == 10'(H_TOTAL - 1));
        w_v_last     = (r_v_cnt == 10'(V_TOTAL - 1));
        w_active     = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
        w_hs_raw     = !((r_h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                         (r_h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
        w_vs_raw     = !((r_v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                         (r_v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));
        w_frame_wrap = w_pix_tick && w_h_last && w_v_last;
    end

    // Pixel divider plus horizontal and vertical raster counters.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_h_cnt   <= 10'd0;
            r_v_cnt   <= 10'd0;
        end else if (w_pix_tick) begin
            r_div_cnt <= '0;
            if (w_h_last) begin
                r_h_cnt <= 10'd0;
                if (w_v_last) begin
                    r_v_cnt <= 10'd0;
                end else begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Output stage: coordinates, enable, raw syncs and the frame strobe.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_row         <= 10'd0;
            r_line        <= 10'd0;
            r_enable      <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_row         <= r_h_cnt;
            r_line        <= r_v_cnt;
            r_enable      <= w_active;
            r_hs          <= w_hs_raw;
            r_vs          <= w_vs_raw;
            r_frame_start <= w_frame_wrap;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.hsync_out = r_hs;
            assign vga.vsync_out = r_vs;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] r_hs_dly;
            logic [SYNC_DELAY-1:0] r_vs_dly;

            // Extra sync delay so hsync/vsync match the registered colour path.
            always_ff @(posedge clk_in or negedge reset_n) begin
                if (!reset_n) begin
                    r_hs_dly <= {SYNC_DELAY{1'b1}};
                    r_vs_dly <= {SYNC_DELAY{1'b1}};
                end else begin
                    r_hs_dly[0] <= r_hs;
                    r_vs_dly[0] <= r_vs;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_hs_dly[i] <= r_hs_dly[i-1];
                        r_vs_dly[i] <= r_vs_dly[i-1];
                    end
                end
            end

            assign vga.hsync_out = r_hs_dly[SYNC_DELAY-1];
            assign vga.vsync_out = r_vs_dly[SYNC_DELAY-1];
        end
    endgenerate

    assign vga.current_row  = r_row;
    assign vga.current_line = r_line;
    assign vga.enable       = r_enable;
    assign vga.frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Self-checking bench for vga_sync_generator using a shrunken raster
// (15 pixels x 8 lines) so whole frames fit in a short run. Instance A uses
// CLK_DIV=2/SYNC_DELAY=1, instance B uses CLK_DIV=1/SYNC_DELAY=0.
module tb_vga_sync_generator;

    // Small raster: H 8/2/3/2 (total 15, sync at 10..12),
    //               V 4/1/2/1 (total 8,  sync at 5..6).
    localparam int HT = 15;
    localparam int VT = 8;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    vga_sync_generator_if if_a ();
    vga_sync_generator_if if_b ();

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SYNC_DELAY(1)
    ) u_dut_a (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .vga     (if_a)
    );

    vga_sync_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_DELAY(0)
    ) u_dut_b (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .vga     (if_b)
    );

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    // Expected outputs k rising edges after reset release (k=0: in reset).
    // Internal counters after k edges sit at pixel k/cd; outputs show the
    // state one edge earlier, syncs 1+sd edges earlier.
    task automatic check_inst(input string n, input int k, input int cd, input int sd,
                              input logic [9:0] row, input logic [9:0] line,
                              input logic en, input logic hs, input logic vs,
                              input logic fs);
        int p, m, hh, vv;
        int e_row, e_line, e_en, e_hs, e_vs, e_fs;
        if (k == 0) begin
            e_row = 0; e_line = 0; e_en = 0;
        end else begin
            p      = (k - 1) / cd;
            e_row  = p % HT;
            e_line = (p / HT) % VT;
            e_en   = (e_row < 8 && e_line < 4) ? 1 : 0;
        end
        m = k - 1 - sd;
        if (m < 0) begin
            e_hs = 1; e_vs = 1;
        end else begin
            hh   = (m / cd) % HT;
            vv   = ((m / cd) / HT) % VT;
            e_hs = (hh >= 10 && hh < 13) ? 0 : 1;
            e_vs = (vv >= 5 && vv < 7) ? 0 : 1;
        end
        e_fs = (k > 0 && (k % (cd * HT * VT)) == 0) ? 1 : 0;
        check({n, "_row"},  int'(row),  e_row);
        check({n, "_line"}, int'(line), e_line);
        check({n, "_en"},   int'(en),   e_en);
        check({n, "_hs"},   int'(hs),   e_hs);
        check({n, "_vs"},   int'(vs),   e_vs);
        check({n, "_fs"},   int'(fs),   e_fs);
    endtask

    int   a_hs_fall[$], a_hs_rise[$], a_vs_fall[$], a_vs_rise[$], a_fs[$];
    int   b_hs_fall[$], b_fs[$];
    int   a_en_line0;
    logic a_hs_p, a_vs_p, b_hs_p;

    // Walk ncyc edges after reset release, comparing every cycle against
    // the model and logging sync edges / strobes for the directed checks.
    task automatic scan(input int ncyc);
        a_hs_fall.delete(); a_hs_rise.delete(); a_vs_fall.delete();
        a_vs_rise.delete(); a_fs.delete(); b_hs_fall.delete(); b_fs.delete();
        a_en_line0 = 0;
        a_hs_p = 1'b1; a_vs_p = 1'b1; b_hs_p = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check_inst("a", k, 2, 1, if_a.current_row, if_a.current_line, if_a.enable,
                       if_a.hsync_out, if_a.vsync_out, if_a.frame_start);
            check_inst("b", k, 1, 0, if_b.current_row, if_b.current_line, if_b.enable,
                       if_b.hsync_out, if_b.vsync_out, if_b.frame_start);
            if (a_hs_p && !if_a.hsync_out) a_hs_fall.push_back(k);
            if (!a_hs_p && if_a.hsync_out) a_hs_rise.push_back(k);
            if (a_vs_p && !if_a.vsync_out) a_vs_fall.push_back(k);
            if (!a_vs_p && if_a.vsync_out) a_vs_rise.push_back(k);
            if (b_hs_p && !if_b.hsync_out) b_hs_fall.push_back(k);
            if (if_a.frame_start) a_fs.push_back(k);
            if (if_b.frame_start) b_fs.push_back(k);
            if (k <= 30 && if_a.enable) a_en_line0++;
            a_hs_p = if_a.hsync_out;
            a_vs_p = if_a.vsync_out;
            b_hs_p = if_b.hsync_out;
        end
    endtask

    initial begin
        bit found;

        // Reset held with the clock running.
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        check_inst("rst_a", 0, 2, 1, if_a.current_row, if_a.current_line, if_a.enable,
                   if_a.hsync_out, if_a.vsync_out, if_a.frame_start);
        check_inst("rst_b", 0, 1, 0, if_b.current_row, if_b.current_line, if_b.enable,
                   if_b.hsync_out, if_b.vsync_out, if_b.frame_start);

        reset_n = 1'b1;
        scan(500);

        // A: pixel = 2 clocks, line = 30 clocks, frame = 240 clocks.
        check("a_hs_first",  qget(a_hs_fall, 0), 22);
        check("a_hs_period", qget(a_hs_fall, 1) - qget(a_hs_fall, 0), 30);
        check("a_hs_width",  qget(a_hs_rise, 0) - qget(a_hs_fall, 0), 6);
        check("a_en_line0",  a_en_line0, 16);
        check("a_vs_first",  qget(a_vs_fall, 0), 152);
        check("a_vs_period", qget(a_vs_fall, 1) - qget(a_vs_fall, 0), 240);
        check("a_vs_width",  qget(a_vs_rise, 0) - qget(a_vs_fall, 0), 60);
        check("a_fs_count",  a_fs.size(), 2);
        check("a_fs_first",  qget(a_fs, 0), 240);
        // B: pixel = 1 clock, no extra sync delay.
        check("b_hs_first",  qget(b_hs_fall, 0), 11);
        check("b_hs_period", qget(b_hs_fall, 1) - qget(b_hs_fall, 0), 15);
        check("b_fs_count",  b_fs.size(), 4);
        check("b_fs_first",  qget(b_fs, 0), 120);

        // Mid-frame reset once instance A shows line 2.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk_in);
            if (if_a.current_line == 10'd2) found = 1'b1;
        end
        check("wait_line2", int'(found), 1);
        reset_n = 1'b0;
        #1;
        check_inst("mrst_a", 0, 2, 1, if_a.current_row, if_a.current_line, if_a.enable,
                   if_a.hsync_out, if_a.vsync_out, if_a.frame_start);
        check_inst("mrst_b", 0, 1, 0, if_b.current_row, if_b.current_line, if_b.enable,
                   if_b.hsync_out, if_b.vsync_out, if_b.frame_start);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset_n = 1'b1;
        scan(250);
        check("a_fs_after_rst",   a_fs.size(), 1);
        check("a_fs_first_rst",   qget(a_fs, 0), 240);
        check("b_fs_after_rst",   b_fs.size(), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
